// File: rtl/bp_fe_pkg.sv
// Shared front-end scan definitions: link registers, opcodes, immediate extraction
// and the registered scan-result struct macro.
`ifndef BP_FE_PKG_SV
`define BP_FE_PKG_SV

`define BP_FE_SLOT_WIDTH(fw) (((fw) > 1) ? $clog2(fw) : 1)

`define DECLARE_BP_FE_SCAN_RAS_S(vw, fw) \
  typedef struct packed { \
    logic cf_v; \
    logic [`BP_FE_SLOT_WIDTH(fw)-1:0] slot; \
    logic branch; \
    logic jal; \
    logic jalr; \
    logic call; \
    logic ret; \
    logic tgt_v; \
    logic [(vw)-1:0] tgt; \
  } bp_fe_scan_ras_s

`define BP_FE_SCAN_RAS_WIDTH(vw, fw) (7 + `BP_FE_SLOT_WIDTH(fw) + (vw))

package bp_fe_pkg;

  localparam logic [6:0] rv_opcode_branch = 7'b1100011;
  localparam logic [6:0] rv_opcode_jal    = 7'b1101111;
  localparam logic [6:0] rv_opcode_jalr   = 7'b1100111;

  localparam logic [4:0] link_x1 = 5'd1;
  localparam logic [4:0] link_x5 = 5'd5;

  function automatic logic is_link(input logic [4:0] r);
    return (r == link_x1) || (r == link_x5);
  endfunction

  function automatic logic [12:0] imm_b(input logic [31:0] i);
    return {i[31], i[7], i[30:25], i[11:8], 1'b0};
  endfunction

  function automatic logic [20:0] imm_j(input logic [31:0] i);
    return {i[31], i[19:12], i[20], i[30:21], 1'b0};
  endfunction

endpackage

`endif

// File: rtl/bp_fe_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module bp_fe_ras
  import bp_fe_pkg::*;
#(
  parameter int vaddr_width_p = 39,
  parameter int ras_els_p     = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     push,
  input  logic                     pop,
  input  logic [vaddr_width_p-1:0] push_addr,
  output logic [vaddr_width_p-1:0] top,
  output logic                     nonempty
);

  localparam int ptr_w = $clog2(ras_els_p);

  logic [vaddr_width_p-1:0] mem [ras_els_p];
  logic [ptr_w-1:0]         tos, tos_pop, tos_n;
  logic [ptr_w:0]           cnt, cnt_pop, cnt_n;

  // A combined pop+push resolves the pop first, so the push reuses the popped slot.
  always_comb begin
    tos_pop = tos;
    cnt_pop = cnt;
    if (pop && (cnt != '0)) begin
      tos_pop = tos - 1'b1;
      cnt_pop = cnt - 1'b1;
    end
    tos_n = tos_pop;
    cnt_n = cnt_pop;
    if (push) begin
      tos_n = tos_pop + 1'b1;
      cnt_n = (cnt_pop == (ptr_w+1)'(ras_els_p)) ? cnt_pop : cnt_pop + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tos <= '0;
      cnt <= '0;
      for (int i = 0; i < ras_els_p; i++) mem[i] <= '0;
    end else begin
      tos <= tos_n;
      cnt <= cnt_n;
      if (push) mem[tos_n] <= push_addr;
    end
  end

  assign top      = mem[tos];
  assign nonempty = (cnt != '0);

endmodule

// File: rtl/bp_fe_scan_ras.sv
// Fetch-block scanner: finds the first control-flow slot, predicts its target and
// maintains the RAS; results sit in a one-entry valid/yumi output register.
module bp_fe_scan_ras
  import bp_fe_pkg::*;
#(
  parameter int vaddr_width_p = 39,
  parameter int fetch_width_p = 2,
  parameter int ras_els_p     = 8,
  localparam int slot_width_lp = `BP_FE_SLOT_WIDTH(fetch_width_p)
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        flush_i,
  input  logic                        v_i,
  output logic                        ready_o,
  input  logic [vaddr_width_p-1:0]    pc_i,
  input  logic [32*fetch_width_p-1:0] instr_i,
  input  logic [fetch_width_p-1:0]    instr_v_i,
  output logic                        v_o,
  input  logic                        yumi_i,
  output logic                        cf_v_o,
  output logic [slot_width_lp-1:0]    slot_o,
  output logic                        branch_o,
  output logic                        jal_o,
  output logic                        jalr_o,
  output logic                        call_o,
  output logic                        ret_o,
  output logic                        tgt_v_o,
  output logic [vaddr_width_p-1:0]    tgt_o
);

  `DECLARE_BP_FE_SCAN_RAS_S(vaddr_width_p, fetch_width_p);
  localparam int res_w = `BP_FE_SCAN_RAS_WIDTH(vaddr_width_p, fetch_width_p);

  logic [fetch_width_p-1:0] br, jal, jalr, call, ret, cf;
  logic [vaddr_width_p-1:0] tgt     [fetch_width_p];
  logic [vaddr_width_p-1:0] link_pc [fetch_width_p];

  for (genvar k = 0; k < fetch_width_p; k++) begin : g_slot
    logic [31:0]              ins;
    logic [vaddr_width_p-1:0] spc;
    logic [4:0]               rd, rs1;
    logic [12:0]              bimm;
    logic [20:0]              jimm;

    assign ins  = instr_i[32*k+:32];
    assign spc  = pc_i + vaddr_width_p'(4*k);
    assign rd   = ins[11:7];
    assign rs1  = ins[19:15];
    assign bimm = imm_b(ins);
    assign jimm = imm_j(ins);

    assign br[k]   = (ins[6:0] == rv_opcode_branch);
    assign jal[k]  = (ins[6:0] == rv_opcode_jal);
    assign jalr[k] = (ins[6:0] == rv_opcode_jalr);
    assign call[k] = (jal[k] | jalr[k]) & is_link(rd);
    assign ret[k]  = jalr[k] & is_link(rs1) & ~(is_link(rd) & (rd == rs1));
    assign cf[k]   = instr_v_i[k] & (br[k] | jal[k] | jalr[k]);

    assign link_pc[k] = spc + vaddr_width_p'(4);
    assign tgt[k] = br[k]  ? spc + {{(vaddr_width_p-13){bimm[12]}}, bimm}
                  : jal[k] ? spc + {{(vaddr_width_p-21){jimm[20]}}, jimm}
                  : '0;
  end

  // Priority encode: lowest-index control-flow slot wins.
  logic [slot_width_lp-1:0] sel;
  logic                     found;
  always_comb begin
    sel = '0;
    for (int k = fetch_width_p-1; k >= 0; k--) begin
      if (cf[k]) sel = slot_width_lp'(k);
    end
  end
  assign found = |cf;

  logic                     ras_top_v;
  logic [vaddr_width_p-1:0] ras_top;
  logic                     accept, ret_hit, call_hit;

  assign ready_o  = (~v_o | yumi_i) & ~flush_i;
  assign accept   = v_i & ready_o;
  assign ret_hit  = found & ret[sel];
  assign call_hit = found & call[sel];

  bp_fe_ras #(
    .vaddr_width_p(vaddr_width_p),
    .ras_els_p    (ras_els_p)
  ) ras (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .push     (accept & call_hit),
    .pop      (accept & ret_hit),
    .push_addr(link_pc[sel]),
    .top      (ras_top),
    .nonempty (ras_top_v)
  );

  bp_fe_scan_ras_s res_n, res_out;
  always_comb begin
    res_n        = '0;
    res_n.cf_v   = found;
    res_n.slot   = found ? sel : '0;
    res_n.branch = found & br[sel];
    res_n.jal    = found & jal[sel];
    res_n.jalr   = found & jalr[sel];
    res_n.call   = call_hit;
    res_n.ret    = ret_hit;
    res_n.tgt_v  = found & (br[sel] | jal[sel] | (ret_hit & ras_top_v));
    res_n.tgt    = ret_hit ? ras_top : (found ? tgt[sel] : '0);
  end

  // Stage p1: registered result and its valid.
  logic [res_w-1:0] res_p1;
  logic             vld_p1;
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      vld_p1 <= 1'b0;
      res_p1 <= '0;
    end else begin
      if (flush_i)     vld_p1 <= 1'b0;
      else if (accept) vld_p1 <= 1'b1;
      else if (yumi_i) vld_p1 <= 1'b0;
      if (accept) res_p1 <= res_n;
    end
  end

  assign res_out  = bp_fe_scan_ras_s'(res_p1);
  assign v_o      = vld_p1;
  assign cf_v_o   = res_out.cf_v;
  assign slot_o   = res_out.slot;
  assign branch_o = res_out.branch;
  assign jal_o    = res_out.jal;
  assign jalr_o   = res_out.jalr;
  assign call_o   = res_out.call;
  assign ret_o    = res_out.ret;
  assign tgt_v_o  = res_out.tgt_v;
  assign tgt_o    = res_out.tgt;

endmodule

// File: tb/tb_bp_fe_scan_ras.sv
// Directed bench for bp_fe_scan_ras with a queue-based RAS reference model.
module tb_bp_fe_scan_ras;

  localparam int VW = 39;
  localparam int FW = 2;
  localparam int RE = 8;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          reset_i, flush_i, v_i, ready_o, yumi_i, v_o;
  logic [VW-1:0] pc_i, tgt_o;
  logic [63:0]   instr_i;
  logic [1:0]    instr_v_i;
  logic          cf_v_o, slot_o, branch_o, jal_o, jalr_o, call_o, ret_o, tgt_v_o;

  always #5 clk = ~clk;

  bp_fe_scan_ras #(.vaddr_width_p(VW), .fetch_width_p(FW), .ras_els_p(RE)) dut (
    .clk_i(clk), .reset_i(reset_i), .flush_i(flush_i), .v_i(v_i), .ready_o(ready_o),
    .pc_i(pc_i), .instr_i(instr_i), .instr_v_i(instr_v_i), .v_o(v_o), .yumi_i(yumi_i),
    .cf_v_o(cf_v_o), .slot_o(slot_o), .branch_o(branch_o), .jal_o(jal_o), .jalr_o(jalr_o),
    .call_o(call_o), .ret_o(ret_o), .tgt_v_o(tgt_v_o), .tgt_o(tgt_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: RAS as a bounded queue, newest at the back.
  logic [VW-1:0] ras_q[$];
  logic          m_v = 1'b0;
  logic          m_cf, m_br, m_jal, m_jalr, m_call, m_ret, m_tv;
  int            m_slot;
  logic [VW-1:0] m_tgt;
  bit            run = 0;

  function automatic logic lnk(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  task automatic model_clear();
    m_cf = 0; m_br = 0; m_jal = 0; m_jalr = 0; m_call = 0; m_ret = 0; m_tv = 0;
    m_slot = 0; m_tgt = '0;
  endtask

  task automatic model_accept(input logic [VW-1:0] pc, input logic [63:0] ins_blk,
                              input logic [1:0] mask);
    logic [31:0]        ins;
    logic [6:0]         op;
    logic [4:0]         rd, rs1;
    logic [VW-1:0]      spc;
    logic signed [12:0] bi;
    logic signed [20:0] ji;
    bit                 done;
    model_clear();
    done = 0;
    for (int k = 0; k < FW; k++) begin
      ins = ins_blk[32*k+:32];
      op  = ins[6:0];
      rd  = ins[11:7];
      rs1 = ins[19:15];
      spc = pc + VW'(4*k);
      if (!done && mask[k] && (op == 7'h63 || op == 7'h6f || op == 7'h67)) begin
        done   = 1;
        m_cf   = 1;
        m_slot = k;
        m_br   = (op == 7'h63);
        m_jal  = (op == 7'h6f);
        m_jalr = (op == 7'h67);
        m_call = (m_jal || m_jalr) && lnk(rd);
        m_ret  = m_jalr && lnk(rs1) && !(lnk(rd) && rd == rs1);
        bi = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        ji = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        if (m_br) begin m_tv = 1; m_tgt = spc + VW'(longint'(bi)); end
        else if (m_jal) begin m_tv = 1; m_tgt = spc + VW'(longint'(ji)); end
        else if (m_ret) begin
          m_tv = (ras_q.size() > 0);
          m_tgt = m_tv ? ras_q[$] : '0;
        end
        if (m_ret && ras_q.size() > 0) void'(ras_q.pop_back());
        if (m_call) begin
          ras_q.push_back(spc + VW'(4));
          if (ras_q.size() > RE) void'(ras_q.pop_front());
        end
      end
    end
  endtask

  // Compare process: outputs against the model whenever a result is valid.
  always @(negedge clk) begin
    if (run) begin
      #1;
      chk("v_o", v_o, m_v);
      if (m_v) begin
        chk("cf_v", cf_v_o, m_cf);
        chk("slot", slot_o, m_slot);
        chk("branch", branch_o, m_br);
        chk("jal", jal_o, m_jal);
        chk("jalr", jalr_o, m_jalr);
        chk("call", call_o, m_call);
        chk("ret", ret_o, m_ret);
        chk("tgt_v", tgt_v_o, m_tv);
        if (m_tv || !m_ret) chk("tgt", tgt_o, m_tgt);
      end
    end
  end

  function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'h000, rs1, 3'b000, rd, 7'b1100111};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm);
    return {imm[12], imm[10:5], 5'd0, 5'd0, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  task automatic step(input logic v, input logic [VW-1:0] pc, input logic [31:0] i0,
                      input logic [31:0] i1, input logic [1:0] mask, input logic ack,
                      input logic fl);
    logic y, rdy, acc;
    @(negedge clk);
    #2;
    y = ack & m_v;
    v_i = v; pc_i = pc; instr_i = {i1, i0}; instr_v_i = mask; yumi_i = y; flush_i = fl;
    rdy = (!m_v || y) && !fl;
    acc = v && rdy;
    #1 chk("ready_o", ready_o, rdy);
    @(posedge clk);
    if (fl) m_v = 0;
    else if (acc) begin model_accept(pc, {i1, i0}, mask); m_v = 1; end
    else if (y) m_v = 0;
    #1;
    v_i = 0; yumi_i = 0; flush_i = 0;
  endtask

  task automatic drain();
    step(1'b0, '0, NOP, NOP, 2'b00, 1'b1, 1'b0);
  endtask

  logic [31:0] ret_x1;

  initial begin
    reset_i = 1; flush_i = 0; v_i = 0; yumi_i = 0; pc_i = '0; instr_i = '0; instr_v_i = '0;
    ret_x1 = enc_jalr(5'd0, 5'd1);
    repeat (2) @(negedge clk);
    #2 reset_i = 0;
    #1;
    chk("rst_v", v_o, 1'b0);
    chk("rst_ready", ready_o, 1'b1);
    chk("rst_cf", cf_v_o, 1'b0);
    chk("rst_tgt", tgt_o, '0);
    run = 1;

    // Single branch in slot 1 behind an addi.
    step(1, 39'h1000, NOP, enc_b(13'h1FF8), 2'b11, 1, 0);
    chk("br_v", v_o, 1'b1);
    chk("br_slot", slot_o, 1'b1);
    chk("br_class", branch_o, 1'b1);
    chk("br_tgt", tgt_o, 39'hFFC);

    // Call then ret.
    step(1, 39'h2000, enc_j(5'd1, 21'h100), NOP, 2'b11, 1, 0);
    chk("call_tgt", tgt_o, 39'h2100);
    chk("call_class", call_o, 1'b1);
    step(1, 39'h3000, ret_x1, NOP, 2'b11, 1, 0);
    chk("ret_class", ret_o, 1'b1);
    chk("ret_tgt_v", tgt_v_o, 1'b1);
    chk("ret_tgt", tgt_o, 39'h2004);

    // Overflow: nine calls, nine rets.
    for (int i = 1; i <= 9; i++) step(1, VW'(i*16), enc_j(5'd1, 21'h40), NOP, 2'b01, 1, 0);
    for (int i = 1; i <= 9; i++) begin
      step(1, VW'(32'h1000 + i*16), ret_x1, NOP, 2'b01, 1, 0);
      if (i == 1) chk("ovf_first", tgt_o, 39'h94);
      if (i == 8) chk("ovf_eighth", tgt_o, 39'h24);
      if (i == 9) chk("ovf_ninth_v", tgt_v_o, 1'b0);
    end

    // Masking and first-slot order.
    step(1, 39'h4000, enc_j(5'd1, 21'h10), enc_j(5'd0, 21'h8), 2'b10, 1, 0);
    chk("mask_slot", slot_o, 1'b1);
    chk("mask_tgt", tgt_o, 39'h400C);
    step(1, 39'h5000, enc_j(5'd1, 21'h10), enc_j(5'd1, 21'h10), 2'b11, 1, 0);
    step(1, 39'h5100, ret_x1, NOP, 2'b01, 1, 0);
    chk("two_call_ret1", tgt_o, 39'h5004);
    step(1, 39'h5200, ret_x1, NOP, 2'b01, 1, 0);
    chk("two_call_ret2_v", tgt_v_o, 1'b0);

    // Combined call+ret, non-ret jalr, and jalr x1,x1 as call only.
    step(1, 39'h8000, enc_j(5'd1, 21'h10), NOP, 2'b01, 1, 0);
    step(1, 39'h9000, enc_jalr(5'd1, 5'd5), NOP, 2'b01, 1, 0);
    chk("cr_tgt", tgt_o, 39'h8004);
    chk("cr_call", call_o, 1'b1);
    step(1, 39'hA000, ret_x1, NOP, 2'b01, 1, 0);
    chk("cr_after", tgt_o, 39'h9004);
    step(1, 39'hB000, enc_jalr(5'd0, 5'd6), NOP, 2'b01, 1, 0);
    chk("jalr_tgt_v", tgt_v_o, 1'b0);
    step(1, 39'hB100, enc_jalr(5'd1, 5'd1), NOP, 2'b01, 1, 0);
    step(1, 39'hB200, ret_x1, NOP, 2'b01, 1, 0);
    chk("x1x1_ret", tgt_o, 39'hB104);

    // Backpressure and flush.
    drain();
    step(1, 39'h6000, enc_j(5'd1, 21'h20), NOP, 2'b01, 0, 0);
    step(1, 39'h7000, enc_j(5'd1, 21'h20), NOP, 2'b01, 0, 0);
    chk("bp_hold_tgt", tgt_o, 39'h6020);
    step(1, 39'h7100, enc_j(5'd1, 21'h20), NOP, 2'b01, 0, 1);
    chk("flush_v", v_o, 1'b0);
    step(1, 39'h7200, ret_x1, NOP, 2'b01, 1, 0);
    chk("bp_ret", tgt_o, 39'h6004);
    step(1, 39'h7300, ret_x1, NOP, 2'b01, 1, 0);
    chk("bp_ret2_v", tgt_v_o, 1'b0);

    // Async reset mid-stream after three pushes.
    for (int i = 1; i <= 3; i++) step(1, VW'(32'hC000 + i*16), enc_j(5'd1, 21'h8), NOP, 2'b01, 1, 0);
    @(negedge clk);
    #2 reset_i = 1;
    #1;
    chk("arst_v", v_o, 1'b0);
    chk("arst_call", call_o, 1'b0);
    chk("arst_tgt", tgt_o, '0);
    ras_q.delete();
    m_v = 0;
    model_clear();
    @(negedge clk);
    #2 reset_i = 0;
    step(1, 39'hD000, ret_x1, NOP, 2'b01, 1, 0);
    chk("arst_ret_v", tgt_v_o, 1'b0);
    chk("arst_ret", ret_o, 1'b1);

    drain();
    drain();
    run = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
